// File: rtl/a_greater_b.sv
// a_greater_b
//   Registered comparator for the ALU datapath. Computes A - B through an
//   explicit ripple borrow chain on (WIDTH+1)-bit extended operands and
//   registers gt/eq/lt one cycle later.
//
// Parameters
//   WIDTH  : operand and result width, 2..32
//   SIGNED : 1 = two's-complement compare, 0 = unsigned compare
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   A, B       operands
//   in_valid   operand pair valid this cycle
//   C          {WIDTH-1 zeros, A > B}, ready for the ALU result mux
//   eq, lt     registered A == B, A < B
//   out_valid  C/eq/lt belong to an accepted operand pair

// One bit of the subtractor: d = a - b - bIn, bOut = borrow out.
module agbBorrowCell (
    input  logic a,
    input  logic b,
    input  logic bIn,
    output logic d,
    output logic bOut
);
    assign d    = a ^ b ^ bIn;
    assign bOut = (~a & b) | (~(a ^ b) & bIn);
endmodule

module a_greater_b #(
    parameter int WIDTH  = 6,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] C,
    output logic             eq,
    output logic             lt,
    output logic             out_valid
);
    localparam int STAGES = 1;

    logic [WIDTH:0] aExt, bExt, diff;
    logic [WIDTH:0] borrow;
    logic           gtNext, eqNext, ltNext;
    logic           gtQ;
    logic [STAGES:0] vldPipe;

    // The extra top bit makes the difference overflow-free, so its MSB is
    // the true sign of A - B in both signed and unsigned modes.
    assign aExt = {(SIGNED ? A[WIDTH-1] : 1'b0), A};
    assign bExt = {(SIGNED ? B[WIDTH-1] : 1'b0), B};

    assign borrow[0] = 1'b0;

    for (genvar g = 0; g < WIDTH; g++) begin : gBit
        agbBorrowCell uCell (
            .a   (aExt[g]),
            .b   (bExt[g]),
            .bIn (borrow[g]),
            .d   (diff[g]),
            .bOut(borrow[g+1])
        );
    end

    // Sign bit of the difference; its borrow-out is not needed.
    assign diff[WIDTH] = aExt[WIDTH] ^ bExt[WIDTH] ^ borrow[WIDTH];

    assign eqNext = ~|diff;
    assign gtNext = ~eqNext & ~diff[WIDTH];
    assign ltNext = ~gtNext & ~eqNext;

    // Result registers only load on accepted pairs, so garbage on A/B while
    // in_valid is low never reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            gtQ <= 1'b0;
            eq  <= 1'b0;
            lt  <= 1'b0;
        end else if (in_valid) begin
            gtQ <= gtNext;
            eq  <= eqNext;
            lt  <= ltNext;
        end
    end

    assign vldPipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (rst) vldPipe[STAGES:1] <= '0;
        else     vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
    end

    assign out_valid = vldPipe[STAGES];
    assign C         = {{(WIDTH-1){1'b0}}, gtQ};
endmodule

// File: tb/tb_a_greater_b.sv
module tb_a_greater_b;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         in_valid;
    logic [W-1:0] C, uC;
    logic         eq, lt, out_valid;
    logic         uEq, uLt, uOutValid;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    a_greater_b #(.WIDTH(W), .SIGNED(1'b1)) dutS (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .C(C), .eq(eq), .lt(lt), .out_valid(out_valid)
    );

    a_greater_b #(.WIDTH(W), .SIGNED(1'b0)) dutU (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .C(uC), .eq(uEq), .lt(uLt), .out_valid(uOutValid)
    );

    typedef struct {
        int a;
        int b;
        int expC;
        int expEq;
        int expLt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] hC;
        logic         hEq, hLt;
        int           sa, sb, g, e, l;

        rst = 1'b1; A = 6'd5; B = 6'd3; in_valid = 1'b1;

        // Reset held two edges with a valid pair present.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_C",  int'(C), 0);
            chk("rst_eq", int'(eq), 0);
            chk("rst_lt", int'(lt), 0);
            chk("rst_ov", int'(out_valid), 0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_C",  int'(C), 1);
        chk("post_rst_ov", int'(out_valid), 1);

        // Signed directed table.
        vecs.push_back('{  5,   3, 1, 0, 0});
        vecs.push_back('{  2,  15, 0, 0, 1});
        vecs.push_back('{ 13, -24, 1, 0, 0});
        vecs.push_back('{-15,  15, 0, 0, 1});
        vecs.push_back('{ 19,  19, 0, 1, 0});
        vecs.push_back('{ -3, -10, 1, 0, 0});
        vecs.push_back('{-25,  -4, 0, 0, 1});
        vecs.push_back('{-32,  31, 0, 0, 1});
        vecs.push_back('{ 31, -32, 1, 0, 0});
        vecs.push_back('{-32, -32, 0, 1, 0});
        vecs.push_back('{  0,  -1, 1, 0, 0});
        vecs.push_back('{ -1,   0, 0, 0, 1});

        foreach (vecs[i]) begin
            A = W'(vecs[i].a);
            B = W'(vecs[i].b);
            in_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d_C", i),  int'(C),  vecs[i].expC);
            chk($sformatf("vec%0d_eq", i), int'(eq), vecs[i].expEq);
            chk($sformatf("vec%0d_lt", i), int'(lt), vecs[i].expLt);
            chk($sformatf("vec%0d_ov", i), int'(out_valid), 1);
        end

        // Unsigned instance: 32 > 31 unsigned, 3 < 62.
        A = 6'b100000; B = 6'b011111;
        tick();
        chk("uns_32_31_C", int'(uC), 1);
        chk("sgn_32_31_C", int'(C), 0);
        A = 6'd3; B = 6'd62;
        tick();
        chk("uns_3_62_C",  int'(uC), 0);
        chk("uns_3_62_lt", int'(uLt), 1);
        chk("sgn_3_62_C",  int'(C), 1);

        // Hold: last accepted pair (3,62) signed => gt.
        hC = C; hEq = eq; hLt = lt;
        chk("hold_base_C", int'(hC), 1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = W'($urandom); B = W'($urandom);
            tick();
            chk("hold_C",  int'(C), 1);
            chk("hold_eq", int'(eq), int'(hEq));
            chk("hold_lt", int'(lt), int'(hLt));
            chk("hold_ov", int'(out_valid), 0);
        end

        // Reset mid-stream discards the pending result.
        A = 6'd31; B = 6'd0; in_valid = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_C",  int'(C), 0);
        chk("mid_rst_ov", int'(out_valid), 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_idle_ov", int'(out_valid), 0);
        chk("mid_idle_C",  int'(C), 0);
        in_valid = 1'b1;
        tick();
        chk("mid_first_C",  int'(C), 1);
        chk("mid_first_ov", int'(out_valid), 1);

        // Back-to-back random pairs, one per cycle.
        for (int i = 0; i < 1000; i++) begin
            A = W'($urandom); B = W'($urandom);
            sa = int'($signed(A)); sb = int'($signed(B));
            g = (sa > sb) ? 1 : 0;
            e = (sa == sb) ? 1 : 0;
            l = (sa < sb) ? 1 : 0;
            tick();
            chk("rnd_C",   int'(C), g);
            chk("rnd_eq",  int'(eq), e);
            chk("rnd_lt",  int'(lt), l);
            chk("rnd_ov",  int'(out_valid), 1);
            chk("rnd_hot", int'(C[0]) + int'(eq) + int'(lt), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
